// File: rtl/adc_map_sequencer.sv
// adc_map_sequencer: steps the ADC channel map through a programmable table.
// Optional post-switch blanking is compiled in with ADC_MAP_SEQ_BLANKING_EN.
module adc_map_sequencer #(
    parameter int ADC_NUM_CHANNELS = 8,
    parameter int TABLE_DEPTH      = 4,
    parameter int DWELL_WIDTH      = 24,
    parameter int BLANK_CYCLES     = 16
) (
    input  logic        sysClk,
    input  logic        sysReset,
    input  logic        csrStrobe,
    input  logic        tableStrobe,
    input  logic        dwellStrobe,
    input  logic [31:0] GPIO_OUT,
    output logic [31:0] csr,
    output logic [31:0] mapOut,
    output logic        mapStrobe,
    output logic        blank
);
    localparam int MB = 3 * ADC_NUM_CHANNELS;
    localparam logic [2:0] LAST_MAX = 3'(TABLE_DEPTH - 1);

    function automatic logic [MB-1:0] ident_map();
        logic [MB-1:0] m;
        m = '0;
        for (int i = 0; i < ADC_NUM_CHANNELS; i++) m[3*i +: 3] = 3'(i);
        return m;
    endfunction

    localparam logic [MB-1:0] IDENT = ident_map();

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DWELL, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [2:0]             idx_q, idx_d;
    logic [2:0]             last_q, last_d;
    logic                   loop_q, loop_d;
    logic [DWELL_WIDTH-1:0] count_q, count_d;
    logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
    logic [MB-1:0]          table_q [TABLE_DEPTH];
    logic [MB-1:0]          table_d [TABLE_DEPTH];
    logic [MB-1:0]          map_q, map_d, map_sel;
    logic                   strobe_q, strobe_d;
    logic                   blank_q;
    logic                   start, stop, pass_end;
    logic [2:0]             csr_last;
    logic [23:0]            map24;
    logic                   unused_gpio;

    assign start       = csrStrobe & GPIO_OUT[0];
    assign stop        = csrStrobe & ~GPIO_OUT[0];
    assign csr_last    = (GPIO_OUT[4:2] > LAST_MAX) ? LAST_MAX : GPIO_OUT[4:2];
    // A pass also ends at the table top when lastIndex was lowered below idx.
    assign pass_end    = (idx_q == last_q) || (idx_q == LAST_MAX);
    assign unused_gpio = &{1'b0, GPIO_OUT[31], GPIO_OUT[27:24]};

    // Sequencer state register.
    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; a stop beats every other transition.
    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:  if (start) state_d = S_LOAD;
                S_LOAD:  state_d = S_DWELL;
                S_DWELL: begin
                    if (count_q == '0) begin
                        if (!pass_end || loop_q) state_d = S_LOAD;
                        else                     state_d = S_DONE;
                    end
                end
                S_DONE:  if (start) state_d = S_LOAD;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Table read mux for the entry being loaded.
    always_comb begin
        map_sel = table_q[0];
        for (int i = 0; i < TABLE_DEPTH; i++)
            if (idx_q == 3'(i)) map_sel = table_q[i];
    end

    // FSM outputs: index stepping, dwell count and the map load.
    always_comb begin
        idx_d    = idx_q;
        count_d  = count_q;
        map_d    = map_q;
        strobe_d = 1'b0;
        if (!stop) begin
            unique case (state_q)
                S_IDLE, S_DONE: if (start) idx_d = '0;
                S_LOAD: begin
                    map_d    = map_sel;
                    strobe_d = 1'b1;
                    count_d  = dwell_q;
                end
                S_DWELL: begin
                    if (count_q != '0) count_d = count_q - DWELL_WIDTH'(1);
                    else if (!pass_end) idx_d = idx_q + 3'd1;
                    else if (loop_q)    idx_d = '0;
                end
                default: ;
            endcase
        end
    end

    // Register-file writes: control, dwell and table entries.
    always_comb begin
        loop_d  = loop_q;
        last_d  = last_q;
        dwell_d = dwell_q;
        table_d = table_q;
        if (csrStrobe) begin
            loop_d = GPIO_OUT[1];
            last_d = csr_last;
        end
        if (dwellStrobe) dwell_d = GPIO_OUT[DWELL_WIDTH-1:0];
        if (tableStrobe)
            for (int i = 0; i < TABLE_DEPTH; i++)
                if (GPIO_OUT[30:28] == 3'(i)) table_d[i] = GPIO_OUT[MB-1:0];
    end

    // Datapath and output registers.
    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            idx_q    <= '0;
            last_q   <= '0;
            loop_q   <= 1'b0;
            count_q  <= '0;
            dwell_q  <= '0;
            map_q    <= IDENT;
            strobe_q <= 1'b0;
            for (int i = 0; i < TABLE_DEPTH; i++) table_q[i] <= IDENT;
        end else begin
            idx_q    <= idx_d;
            last_q   <= last_d;
            loop_q   <= loop_d;
            count_q  <= count_d;
            dwell_q  <= dwell_d;
            map_q    <= map_d;
            strobe_q <= strobe_d;
            table_q  <= table_d;
        end
    end

`ifdef ADC_MAP_SEQ_BLANKING_EN
    localparam int BW = $clog2(BLANK_CYCLES + 1);

    logic [BW-1:0] blank_cnt_q, blank_cnt_d;
    logic          blank_d;

    // Blank window restarts on every map strobe and runs out on its own.
    always_comb begin
        blank_cnt_d = blank_cnt_q;
        if (strobe_q)                blank_cnt_d = BW'(BLANK_CYCLES);
        else if (blank_cnt_q != '0)  blank_cnt_d = blank_cnt_q - BW'(1);
        blank_d = strobe_q || (blank_cnt_q > BW'(1));
    end

    // Blanking registers.
    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            blank_cnt_q <= '0;
            blank_q     <= 1'b0;
        end else begin
            blank_cnt_q <= blank_cnt_d;
            blank_q     <= blank_d;
        end
    end
`else
    logic [31:0] unused_blank_cycles;
    assign unused_blank_cycles = 32'(BLANK_CYCLES);
    assign blank_q = 1'b0;
`endif

    // Zero-extend the map fields to the 24-bit readback slot.
    always_comb begin
        map24         = '0;
        map24[MB-1:0] = map_q;
    end

    assign mapOut    = {8'h00, map24};
    assign mapStrobe = strobe_q;
    assign blank     = blank_q;
    assign csr       = {map24, blank_q, 2'b00, idx_q,
                        state_q == S_DONE,
                        (state_q == S_LOAD) || (state_q == S_DWELL)};
endmodule

// File: doc/adc_map_sequencer.md
# adc_map_sequencer

Sequences the ADC physical-to-logical channel map through a small programmable table in the sysClk domain. Each table entry is applied for a programmed dwell, then the next entry is applied. The resulting 32-bit map word drives the mapping crossbar's map input in place of a static CSR value. Intended uses are channel-rotation calibration and cross-talk scans without software timing in the loop.

## Interface
- `ADC_NUM_CHANNELS`, default 8: logical channels. Each channel has a 3-bit map field; values above 8 are unsupported.
- `TABLE_DEPTH`, default 4: number of map table entries, 2..8.
- `DWELL_WIDTH`, default 24: width of the dwell counter.
- `BLANK_CYCLES`, default 16: post-switch blanking length. Used only when blanking is compiled in.
- `sysClk`, in, 1: the single clock.
- `sysReset`, in, 1: reset, asynchronous and active-high.
- `csrStrobe`, in, 1: write the control register from `GPIO_OUT`.
- `tableStrobe`, in, 1: write a table entry from `GPIO_OUT`.
- `dwellStrobe`, in, 1: write the dwell value from `GPIO_OUT[DWELL_WIDTH-1:0]`.
- `GPIO_OUT`, in, 32: write data.
- `csr`, out, 32: status readback.
- `mapOut`, out, 32: map word to the crossbar. Bits [23:0] are the fields; bits [31:24] are always 0.
- `mapStrobe`, out, 1: one-cycle pulse on each new `mapOut` value.
- `blank`, out, 1: the downstream data is unsettled and must be discarded.

## Operation
- **Control register** (`csrStrobe`):
  - bit0 `run`.
  - bit1 `loop`.
  - bits[4:2] `lastIndex`, saturated to TABLE_DEPTH-1.
- **Table write** (`tableStrobe`):
  - `GPIO_OUT[30:28]` selects the entry; indices at or above TABLE_DEPTH are ignored.
  - `GPIO_OUT[23:0]` is the map word.
  - Writes are allowed while running; a new value takes effect at that entry's next LOAD.
- **Dwell write** (`dwellStrobe`): one dwell value common to all entries. It is sampled at each LOAD.
- **State machine**: IDLE, LOAD, DWELL, DONE.
  - IDLE: a `csrStrobe` with bit0=1 sets idx=0 and goes to LOAD.
  - LOAD: mapOut <= table[idx], mapStrobe=1, count <= dwell, then go to DWELL.
  - DWELL: if count==0, evaluate the exit rule below; otherwise count <= count-1.
  - DWELL exit, idx≠lastIndex: idx+1, go to LOAD.
  - DWELL exit, idx==lastIndex and loop=1: idx=0, go to LOAD.
  - DWELL exit, idx==lastIndex and loop=0: go to DONE.
  - DONE: hold mapOut. A `csrStrobe` with bit0=1 restarts at idx 0 (LOAD); bit0=0 goes to IDLE.
- **Stop**: a `csrStrobe` with bit0=0 in any state goes to IDLE on the next edge.
  - mapOut holds its current value.
  - No mapStrobe is issued.
  - idx is preserved for readback.
- **Priority**: if a `csrStrobe` with bit0=0 coincides with a DWELL exit, the stop wins and no LOAD occurs. A `csrStrobe` with bit0=1 while already in LOAD or DWELL only updates `loop` and `lastIndex`; the sequence does not restart.
- **lastIndex lowered below idx mid-run**: the sequence continues until idx reaches TABLE_DEPTH-1, then applies the wrap or stop rule. The index always wraps at TABLE_DEPTH.
- **csr status**:
  - bit0 running (LOAD or DWELL).
  - bit1 done.
  - bits[4:2] idx.
  - bits[7:5] 0.
  - bits[31:8] mapOut[23:0].
- **Reset values**:
  - State IDLE, idx 0, dwell 0.
  - run, loop and lastIndex 0.
  - Every table entry and mapOut[23:0] = identity map 24'hFAC688 (field i = i).
  - mapStrobe 0, blank 0.

## Timing
- A `csrStrobe` start at edge t gives LOAD at t+1; mapOut and mapStrobe are visible after edge t+1.
- One entry period is dwell+2 cycles: 1 LOAD + dwell+1 DWELL.
- The next mapStrobe follows the previous one by dwell+2 cycles.
- With dwell=0, mapStrobe pulses every 2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.
- mapStrobe is never high on consecutive cycles.

## Configuration
- Macro `ADC_MAP_SEQ_BLANKING_EN`.
- **Defined**:
  - `blank` rises on the edge after each mapStrobe and stays high for exactly BLANK_CYCLES cycles. This covers the downstream clock-crossing and crossbar latency.
  - A new mapStrobe during blanking reloads the blank counter.
  - A stop does not cut blanking short.
  - csr bit7 = blank.
- **Undefined**: `blank` is constant 0, csr bit7 = 0, and BLANK_CYCLES is ignored.

## Test plan
- **Reset defaults**: assert sysReset mid-DWELL (dwell=100) → mapOut=32'h00FAC688, csr=32'hFAC68800, mapStrobe=0 and blank=0 immediately (asynchronous).
- **Single pass**: entries 0..2 = 24'h000001, 24'h000002, 24'h000003; dwell=3; lastIndex=2; loop=0; run=1 → three mapStrobes 5 cycles apart with those values, then DONE (csr bit1=1, bits[4:2]=2), and mapOut holds 24'h000003.
- **Loop wrap**: same setup with loop=1 → entry 0 is reapplied 5 cycles after entry 2, and the 2→0 sequence repeats indefinitely.
- **Stop coincident with a DWELL exit**: issue the csrStrobe with bit0=0 on the exit cycle → no further mapStrobe, csr bit0=0, mapOut unchanged.
- **Live table write and dwell=0**: with dwell=0, write entry 1 = 24'h123456 while entry 0 is active → mapStrobe every 2 cycles, and the next entry-1 load outputs 24'h123456.
- **Blanking** (macro defined, BLANK_CYCLES=16, dwell=8, period 10 cycles) → blank stays continuously high from one cycle after the first mapStrobe until 16 cycles after the last. Undefined build → blank stays 0.
